// File: rtl/uart_mmio_if.sv
// Data-bus connection between the core's memory map and the UART peripheral.
// The master drives a request and holds it until the one-cycle ack pulse.
interface uart_mmio_if;
  logic [3:0]  data_addr;
  logic [31:0] data_wr_data;
  logic [3:0]  data_mask;
  logic        data_wr_en;
  logic        data_req;
  logic        data_ack;
  logic [31:0] data_rd_data;

  modport master (
    output data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    input  data_ack, data_rd_data
  );

  modport slave (
    input  data_addr, data_wr_data, data_mask, data_wr_en, data_req,
    output data_ack, data_rd_data
  );
endinterface

// File: rtl/uart_mmio.sv
// Memory-mapped full-duplex UART with TX/RX FIFOs, runtime baud divisor,
// sticky error flags and a level interrupt.
// Register map (byte offsets): 0x0 DATA, 0x4 STATUS, 0x8 DIVISOR, 0xC IRQ_EN.
module uart_mmio #(
  parameter int CLK_SPEED = 100_000_000,
  parameter int BAUDRATE  = 115200,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic       clk,
  input  logic       rstz,
  uart_mmio_if.slave bus,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);

  localparam logic [15:0] DIV_RESET = 16'(CLK_SPEED / BAUDRATE - 1);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_e;

  // Bus / control registers
  logic        ack_q;
  logic [31:0] rd_q;
  logic [15:0] div_q;
  logic [1:0]  irq_en_q;
  logic        irq_q, overrun_q, frame_err_q;

  // FIFOs
  logic [7:0]   tx_mem [TX_DEPTH];
  logic [7:0]   rx_mem [RX_DEPTH];
  logic [TAW-1:0] tx_wp_q, tx_rp_q;
  logic [TAW:0]   tx_cnt_q;
  logic [RAW-1:0] rx_wp_q, rx_rp_q;
  logic [RAW:0]   rx_cnt_q;

  // Serial engines
  tx_state_e tx_state_q, tx_state_d;
  logic [15:0] tx_tmr_q, tx_tmr_d;
  logic [2:0]  tx_bit_q, tx_bit_d;
  logic [7:0]  tx_sh_q, tx_sh_d;
  logic        tx_line_q, tx_line_d;
  rx_state_e rx_state_q, rx_state_d;
  logic [15:0] rx_tmr_q, rx_tmr_d;
  logic [2:0]  rx_bit_q, rx_bit_d;
  logic [7:0]  rx_sh_q, rx_sh_d;
  logic [1:0]  rx_sync_q;

  logic        tx_full, tx_empty, rx_full, rx_empty, tx_busy;
  logic        tx_push, tx_pop, rx_push, rx_push_ok, rx_pop, rx_ferr_set, rx_ovr_set;
  logic        req_go, wr_tx, accept;
  logic [1:0]  sel;
  logic [31:0] rd_val;
  logic [15:0] bit_div;
  logic        rx_s;

  assign tx_full  = (tx_cnt_q == (TAW+1)'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == (RAW+1)'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign tx_busy  = (tx_state_q != TX_IDLE);
  assign bit_div  = (div_q < 16'd3) ? 16'd3 : div_q;
  assign rx_s     = rx_sync_q[1];

  // Bus decode: accept one request per two cycles; a DATA write into a full
  // TX FIFO waits until the transmitter frees a slot in the same cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel    = bus.data_addr[3:2];
    req_go = bus.data_req & ~ack_q;
    wr_tx  = req_go & bus.data_wr_en & (sel == 2'd0) & bus.data_mask[0];
    accept = req_go & ~(wr_tx & tx_full & ~tx_pop);
    tx_push = accept & wr_tx;
    rx_pop  = accept & ~bus.data_wr_en & (sel == 2'd0) & ~rx_empty;
    rd_val  = '0;
    case (sel)
      2'd0: if (!rx_empty) rd_val = {1'b1, 23'b0, rx_mem[rx_rp_q]};
      2'd1: rd_val = {25'b0, tx_busy, frame_err_q, overrun_q, rx_full, rx_empty, tx_empty, tx_full};
      2'd2: rd_val = {16'b0, div_q};
      default: rd_val = {30'b0, irq_en_q};
    endcase
  end

  // Bus response, configuration registers, sticky flags and interrupt
  always_ff @(posedge clk or negedge rstz) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rstz) begin
      ack_q       <= 1'b0;
      rd_q        <= '0;
      div_q       <= DIV_RESET;
      irq_en_q    <= '0;
      irq_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      ack_q <= accept;
      rd_q  <= (accept && !bus.data_wr_en) ? rd_val : '0;
      if (accept && bus.data_wr_en) begin
        case (sel)
          2'd1: if (bus.data_mask[0]) begin
            if (bus.data_wr_data[4]) overrun_q   <= 1'b0;
            if (bus.data_wr_data[5]) frame_err_q <= 1'b0;
          end
          2'd2: begin
            if (bus.data_mask[0]) div_q[7:0]  <= bus.data_wr_data[7:0];
            if (bus.data_mask[1]) div_q[15:8] <= bus.data_wr_data[15:8];
          end
          2'd3: if (bus.data_mask[0]) irq_en_q <= bus.data_wr_data[1:0];
          default: ;
        endcase
      end
      if (rx_ovr_set)  overrun_q   <= 1'b1;
      if (rx_ferr_set) frame_err_q <= 1'b1;
      irq_q <= |(irq_en_q & {tx_empty & ~tx_busy, ~rx_empty});
    end
  end

  assign rx_push_ok = rx_push & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

  // FIFO storage writes
  always_ff @(posedge clk) begin
    // NOTE: FIFO storage has no reset; the counts and pointers alone define valid contents.
    if (tx_push)    tx_mem[tx_wp_q] <= bus.data_wr_data[7:0];
    if (rx_push_ok) rx_mem[rx_wp_q] <= rx_sh_q;
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      tx_wp_q <= '0; tx_rp_q <= '0; tx_cnt_q <= '0;
      rx_wp_q <= '0; rx_rp_q <= '0; rx_cnt_q <= '0;
    end else begin
      if (tx_push) tx_wp_q <= tx_wp_q + TAW'(1);
      if (tx_pop)  tx_rp_q <= tx_rp_q + TAW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt_q <= tx_cnt_q + (TAW+1)'(1);
        2'b01:   tx_cnt_q <= tx_cnt_q - (TAW+1)'(1);
        default: ;
      endcase
      if (rx_push_ok) rx_wp_q <= rx_wp_q + RAW'(1);
      if (rx_pop)     rx_rp_q <= rx_rp_q + RAW'(1);
      case ({rx_push_ok, rx_pop})
        2'b10:   rx_cnt_q <= rx_cnt_q + (RAW+1)'(1);
        2'b01:   rx_cnt_q <= rx_cnt_q - (RAW+1)'(1);
        default: ;
      endcase
    end
  end

  // TX next state: each state lasts bit_div+1 clocks; STOP chains straight into START
  always_comb begin
    tx_state_d = tx_state_q;
    tx_tmr_d   = tx_tmr_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_line_d  = tx_line_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        tx_line_d = 1'b1;
        if (!tx_empty) begin
          tx_pop = 1'b1; tx_sh_d = tx_mem[tx_rp_q];
          tx_state_d = TX_START; tx_tmr_d = bit_div; tx_line_d = 1'b0;
        end
      end
      TX_START:
        if (tx_tmr_q == '0) begin
          tx_state_d = TX_DATA; tx_tmr_d = bit_div; tx_bit_d = '0; tx_line_d = tx_sh_q[0];
        end else tx_tmr_d = tx_tmr_q - 16'd1;
      TX_DATA:
        if (tx_tmr_q == '0) begin
          tx_tmr_d = bit_div;
          if (tx_bit_q == 3'd7) begin
            tx_state_d = TX_STOP; tx_line_d = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 3'd1; tx_sh_d = {1'b0, tx_sh_q[7:1]}; tx_line_d = tx_sh_q[1];
          end
        end else tx_tmr_d = tx_tmr_q - 16'd1;
      default:  // TX_STOP
        if (tx_tmr_q == '0) begin
          if (!tx_empty) begin
            tx_pop = 1'b1; tx_sh_d = tx_mem[tx_rp_q];
            tx_state_d = TX_START; tx_tmr_d = bit_div; tx_line_d = 1'b0;
          end else begin
            tx_state_d = TX_IDLE; tx_line_d = 1'b1;
          end
        end else tx_tmr_d = tx_tmr_q - 16'd1;
    endcase
  end

  // RX next state: half-bit start check, then mid-bit samples. IDLE is only
  // entered with the line high, so a low level there is a falling edge.
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tmr_d    = rx_tmr_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    rx_push     = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE:
        if (!rx_s) begin
          rx_state_d = RX_START; rx_tmr_d = bit_div >> 1;
        end
      RX_START:
        if (rx_tmr_q == '0) begin
          if (rx_s) rx_state_d = RX_IDLE;
          else begin
            rx_state_d = RX_DATA; rx_tmr_d = bit_div; rx_bit_d = '0;
          end
        end else rx_tmr_d = rx_tmr_q - 16'd1;
      RX_DATA:
        if (rx_tmr_q == '0) begin
          rx_sh_d  = {rx_s, rx_sh_q[7:1]};
          rx_tmr_d = bit_div;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 3'd1;
        end else rx_tmr_d = rx_tmr_q - 16'd1;
      RX_STOP:
        if (rx_tmr_q == '0) begin
          if (rx_s) begin
            rx_push = 1'b1; rx_state_d = RX_IDLE;
          end else begin
            rx_ferr_set = 1'b1; rx_state_d = RX_WAIT;
          end
        end else rx_tmr_d = rx_tmr_q - 16'd1;
      default:  // RX_WAIT: line must return high before a new frame
        if (rx_s) rx_state_d = RX_IDLE;
    endcase
  end

  // Serial engine state registers and input synchroniser
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      tx_state_q <= TX_IDLE; tx_tmr_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0; tx_line_q <= 1'b1;
      rx_state_q <= RX_IDLE; rx_tmr_q <= '0; rx_bit_q <= '0; rx_sh_q <= '0; rx_sync_q <= 2'b11;
    end else begin
      tx_state_q <= tx_state_d; tx_tmr_q <= tx_tmr_d; tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d; tx_line_q <= tx_line_d;
      rx_state_q <= rx_state_d; rx_tmr_q <= rx_tmr_d; rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d; rx_sync_q <= {rx_sync_q[0], uart_rx};
    end
  end

  assign bus.data_ack     = ack_q;
  assign bus.data_rd_data = rd_q;
  assign uart_tx          = tx_line_q;
  assign irq              = irq_q;

  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, bus.data_addr[1:0], bus.data_wr_data[31:16], bus.data_mask[3:2]};

endmodule
